// File: rtl/sample_timer_pkg.sv
// sample_timer_pkg: shared definitions for the IFC sample-clock generator.
//   - CNT_W            : width of every channel counter and period.
//   - scp_unit_e       : channel-5 period unit codes.
//   - CHn_US           : fixed-channel periods in microseconds.
//   - us_to_cycles()   : converts a microsecond count to system-clock cycles.
package sample_timer_pkg;

    localparam int unsigned CNT_W = 24;

    typedef enum logic [1:0] {
        SCP_UNIT_CLK   = 2'd0,
        SCP_UNIT_US    = 2'd1,
        SCP_UNIT_10US  = 2'd2,
        SCP_UNIT_100US = 2'd3
    } scp_unit_e;

    localparam int unsigned CH1_US = 1;
    localparam int unsigned CH2_US = 10;
    localparam int unsigned CH3_US = 100;
    localparam int unsigned CH4_US = 1000;

    function automatic logic [CNT_W-1:0] us_to_cycles(input int unsigned freq,
                                                      input int unsigned us);
        return CNT_W'(freq * us);
    endfunction

endpackage

// File: rtl/sample_clk_div.sv
// sample_clk_div: one square-wave sample-clock channel.
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   en     in   channel enable (synchronous level)
//   period in   requested period in cycles, sampled only at period boundaries
//   clk_o  out  registered sample clock, high for floor(P/2) of every P cycles
module sample_clk_div
    import sample_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    output logic             clk_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             out_q, out_d;

    // cnt_q holds the phase that will be presented on the next edge.
    // A latched period below 2 marks the channel as idle/held: the load is
    // retried every cycle, which also covers the idle -> run start.
    always_comb begin
        cnt_d = cnt_q;
        per_d = per_q;
        out_d = out_q;
        if (!en) begin
            cnt_d = '0;
            per_d = '0;
            out_d = 1'b0;
        end else if (per_q < CNT_W'(2)) begin
            per_d = period;
            if (period >= CNT_W'(2)) begin
                cnt_d = CNT_W'(1);
                out_d = 1'b1;
            end else begin
                cnt_d = '0;
                out_d = 1'b0;
            end
        end else begin
            out_d = (cnt_q < (per_q >> 1));
            if (cnt_q == per_q - CNT_W'(1)) begin
                cnt_d = '0;
                per_d = period;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            per_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
            out_q <= out_d;
        end
    end

    assign clk_o = out_q;

endmodule

// File: rtl/ifc_sample_timer.sv
// ifc_sample_timer: five-channel sample-clock generator.
//   freq        parameter  system clock in MHz (cycles per us), >= 2
//   clk, rst_n  in         system clock, asynchronous active-low reset
//   en1..en5    in         per-channel enables
//   scp_period  in         channel-5 period count (10 bits)
//   scp_unit    in         channel-5 unit: clk / 1 us / 10 us / 100 us
//   clk_o1..4   out        fixed 1 us / 10 us / 100 us / 1 ms sample clocks
//   clk_o5      out        programmable scope sample clock
// Build option: define SAMPLE_TIMER_SCP_EN to build channel 5; otherwise
// clk_o5 is tied low and en5/scp_period/scp_unit are ignored.
module ifc_sample_timer
    import sample_timer_pkg::*;
#(
    parameter int unsigned freq = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en1,
    input  logic       en2,
    input  logic       en3,
    input  logic       en4,
    input  logic       en5,
    input  logic [9:0] scp_period,
    input  logic [1:0] scp_unit,
    output logic       clk_o1,
    output logic       clk_o2,
    output logic       clk_o3,
    output logic       clk_o4,
    output logic       clk_o5
);

    localparam logic [CNT_W-1:0] P1 = us_to_cycles(freq, CH1_US);
    localparam logic [CNT_W-1:0] P2 = us_to_cycles(freq, CH2_US);
    localparam logic [CNT_W-1:0] P3 = us_to_cycles(freq, CH3_US);
    localparam logic [CNT_W-1:0] P4 = us_to_cycles(freq, CH4_US);

    sample_clk_div u_ch1 (.clk(clk), .rst_n(rst_n), .en(en1), .period(P1), .clk_o(clk_o1));
    sample_clk_div u_ch2 (.clk(clk), .rst_n(rst_n), .en(en2), .period(P2), .clk_o(clk_o2));
    sample_clk_div u_ch3 (.clk(clk), .rst_n(rst_n), .en(en3), .period(P3), .clk_o(clk_o3));
    sample_clk_div u_ch4 (.clk(clk), .rst_n(rst_n), .en(en4), .period(P4), .clk_o(clk_o4));

`ifdef SAMPLE_TIMER_SCP_EN
    localparam logic [CNT_W-1:0] MULT_US    = us_to_cycles(freq, 1);
    localparam logic [CNT_W-1:0] MULT_10US  = us_to_cycles(freq, 10);
    localparam logic [CNT_W-1:0] MULT_100US = us_to_cycles(freq, 100);

    logic [CNT_W-1:0] p5;

    // Constant multipliers only; 1023 * 100 * freq fits 24 bits for freq <= 163.
    always_comb begin
        p5 = CNT_W'(scp_period);
        unique case (scp_unit_e'(scp_unit))
            SCP_UNIT_CLK:   p5 = CNT_W'(scp_period);
            SCP_UNIT_US:    p5 = CNT_W'(scp_period) * MULT_US;
            SCP_UNIT_10US:  p5 = CNT_W'(scp_period) * MULT_10US;
            SCP_UNIT_100US: p5 = CNT_W'(scp_period) * MULT_100US;
        endcase
    end

    sample_clk_div u_ch5 (.clk(clk), .rst_n(rst_n), .en(en5), .period(p5), .clk_o(clk_o5));
`else
    logic unused_scp;
    assign unused_scp = ^{en5, scp_period, scp_unit};
    assign clk_o5     = 1'b0;
`endif

endmodule

// File: tb/tb_ifc_sample_timer.sv
// tb_ifc_sample_timer: randomized scoreboard bench for ifc_sample_timer.
// The driver updates a phase-based reference model after every clock edge and
// queues the expected output vector; a monitor compares on the falling edge.
module tb_ifc_sample_timer;

    localparam int unsigned FREQ = 10;

`ifdef SAMPLE_TIMER_SCP_EN
    localparam bit SCP = 1'b1;
`else
    localparam bit SCP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] en;
    logic [9:0] scp_period;
    logic [1:0] scp_unit;
    logic       clk_o1, clk_o2, clk_o3, clk_o4, clk_o5;

    always #5 clk = ~clk;

    ifc_sample_timer #(.freq(FREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en1       (en[0]),
        .en2       (en[1]),
        .en3       (en[2]),
        .en4       (en[3]),
        .en5       (en[4]),
        .scp_period(scp_period),
        .scp_unit  (scp_unit),
        .clk_o1    (clk_o1),
        .clk_o2    (clk_o2),
        .clk_o3    (clk_o3),
        .clk_o4    (clk_o4),
        .clk_o5    (clk_o5)
    );

    int checks   = 0;
    int failures = 0;
    logic [4:0] exp_q[$];

    // Reference model: each channel is either inactive or running a period of
    // m_cur cycles that began at edge m_start.
    bit     m_act  [5];
    longint m_start[5];
    longint m_cur  [5];
    longint m_next [5];
    longint t = 0;

    function automatic longint req_period(int ch);
        longint mult;
        case (ch)
            0: return longint'(FREQ);
            1: return longint'(10 * FREQ);
            2: return longint'(100 * FREQ);
            3: return longint'(1000 * FREQ);
            default: begin
                case (scp_unit)
                    2'd0:    mult = 1;
                    2'd1:    mult = FREQ;
                    2'd2:    mult = 10 * FREQ;
                    default: mult = 100 * FREQ;
                endcase
                return longint'(scp_period) * mult;
            end
        endcase
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < 5; ch++) m_act[ch] = 1'b0;
    endtask

    task automatic model_edge();
        longint pin;
        longint ph;
        t++;
        for (int ch = 0; ch < 5; ch++) begin
            pin = req_period(ch);
            if (!en[ch]) begin
                m_act[ch] = 1'b0;
            end else begin
                if (m_act[ch]) begin
                    ph = t - m_start[ch];
                    if (ph == m_cur[ch] - 1) m_next[ch] = pin;
                    if (ph == m_cur[ch]) begin
                        if (m_next[ch] >= 2) begin
                            m_cur[ch]   = m_next[ch];
                            m_start[ch] = t;
                        end else begin
                            m_act[ch] = 1'b0;
                        end
                    end
                end
                if (!m_act[ch] && pin >= 2) begin
                    m_act[ch]   = 1'b1;
                    m_start[ch] = t;
                    m_cur[ch]   = pin;
                end
            end
        end
    endtask

    function automatic logic [4:0] model_out();
        logic [4:0] v;
        for (int ch = 0; ch < 5; ch++) begin
            v[ch] = m_act[ch] && ((t - m_start[ch]) < (m_cur[ch] / 2));
        end
        if (!SCP) v[4] = 1'b0;
        return v;
    endfunction

    // Wait for an edge and advance the model with the inputs seen at it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) model_edge();
        else begin
            t++;
            model_reset();
        end
    endtask

    // Queue the expectation after any input change made since tick().
    task automatic push_exp();
        if (!rst_n) model_reset();
        exp_q.push_back(model_out());
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            tick();
            push_exp();
        end
    endtask

    // Monitor: compare once per cycle, away from the active edge.
    initial begin
        logic [4:0] e;
        logic [4:0] a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {clk_o5, clk_o4, clk_o3, clk_o2, clk_o1};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL clk_o t=%0d got=%b exp=%b", t, a, e);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog t=%0d got=timeout exp=finish", t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        en         = 5'h1F;
        scp_period = 10'd10;
        scp_unit   = 2'd0;
        model_reset();

        // Reset held with everything enabled.
        run(2);
        tick();
        rst_n = 1'b1;
        push_exp();

        // scp 10 clk, then 20 clk mid-period.
        run(37);
        tick();
        scp_period = 10'd20;
        push_exp();
        run(80);

        // Drop en1 while high, then re-enable.
        for (int i = 0; i < 200; i++) begin
            tick();
            if (m_act[0] && (t - m_start[0]) == 2) begin
                en[0] = 1'b0;
                push_exp();
                break;
            end
            push_exp();
        end
        run(3);
        tick();
        en[0] = 1'b1;
        push_exp();
        run(50);

        // Short and degenerate channel-5 periods.
        tick();
        scp_period = 10'd3;
        push_exp();
        run(40);
        tick();
        scp_period = 10'd1;
        push_exp();
        run(40);
        tick();
        scp_period = 10'd0;
        push_exp();
        run(20);
        tick();
        scp_period = 10'd2;
        scp_unit   = 2'd1;
        push_exp();
        run(450);

        // Asynchronous reset between edges while channels are running.
        tick();
        rst_n = 1'b0;
        push_exp();
        run(2);
        tick();
        rst_n = 1'b1;
        push_exp();

        // Randomized phase; en4 left alone early so channel 4 completes periods.
        for (int i = 0; i < 21000 && failures < 30; i++) begin
            tick();
            if ($urandom_range(0, 299) == 0) begin
                int b;
                b = (i < 12000) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 4));
                if (i < 12000 && $urandom_range(0, 1) == 1) b = 4;
                en[b] = ~en[b];
            end
            if ($urandom_range(0, 49) == 0) begin
                int u;
                u = int'($urandom_range(0, 63));
                if (u < 52) begin
                    scp_unit   = 2'd0;
                    scp_period = 10'($urandom_range(0, 25));
                end else if (u < 60) begin
                    scp_unit   = 2'd1;
                    scp_period = 10'($urandom_range(0, 25));
                end else if (u < 63) begin
                    scp_unit   = 2'd2;
                    scp_period = 10'($urandom_range(0, 12));
                end else begin
                    scp_unit   = 2'd3;
                    scp_period = 10'($urandom_range(0, 2));
                end
            end
            push_exp();
        end

        // Drain the scoreboard.
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
